// File: rtl/reorder_input_arbiter_pkg.sv
// Shared definitions for the reorder input arbiter: controller states and index-width helper.
package reorder_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HOLD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Index width for a requester number; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reorder_input_arbiter_if.sv
// Requester-side bundle of the reorder input arbiter: per-requester handshake plus the datapath feed.
interface reorder_input_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int TENSOR_WIDTH = 128,
    parameter int COUNT_WIDTH  = 32
);

    logic                                   start;
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ-1:0]                     req_last;
    logic [NUM_REQ-1:0][TENSOR_WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0]                     req_ready;
    logic                                   out_en;
    logic [TENSOR_WIDTH-1:0]                out_element;
    logic                                   busy;
    logic                                   done;
    logic [COUNT_WIDTH-1:0]                 elem_count;

    modport master (
        output start, req_valid, req_last, req_data,
        input  req_ready, out_en, out_element, busy, done, elem_count
    );

    modport slave (
        input  start, req_valid, req_last, req_data,
        output req_ready, out_en, out_element, busy, done, elem_count
    );

endinterface

// File: rtl/reorder_input_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: first eligible requester after the last-served pointer.
module rr_arbiter
    import reorder_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_gnt_idx,
    output logic               o_any
);

    // Scan ptr+1, ptr+2, ... so the most recently served requester is considered last.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_any     = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_elig[idx]) begin
                o_any       = 1'b1;
                o_gnt[idx]  = 1'b1;
                o_gnt_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reorder_input_arbiter.sv
// Shares the reorder datapath input between NUM_REQ producers, round-robin, one element per ISSUE_INTERVAL cycles.
module reorder_input_arbiter
    import reorder_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TENSOR_WIDTH   = 128,
    parameter int ISSUE_INTERVAL = 3,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    reorder_input_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(ISSUE_INTERVAL) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(ISSUE_INTERVAL - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ISSUE_INTERVAL);

    state_t                     r_state;
    state_t                     w_nextState;
    logic [NUM_REQ-1:0]         r_fin;
    logic [IDX_W-1:0]           r_ptr;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_outEn;
    logic [TENSOR_WIDTH-1:0]    r_outElement;
    logic [COUNT_WIDTH-1:0]     r_elemCount;

    logic [NUM_REQ-1:0]         w_elig;
    logic [NUM_REQ-1:0]         w_gnt;
    logic [IDX_W-1:0]           w_gntIdx;
    logic                       w_any;
    logic [NUM_REQ-1:0]         w_reqReady;
    logic                       w_busy;
    logic                       w_done;
    logic                       w_xfer;
    logic                       w_allFin;
    logic                       w_startJob;

    assign w_elig     = bus.req_valid & ~r_fin;
    assign w_allFin   = &r_fin;
    assign w_xfer     = |(bus.req_valid & w_reqReady);
    assign w_startJob = bus.start && (r_state == ST_IDLE || r_state == ST_DONE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rrArbiter (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gntIdx),
        .o_any     (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // r_cnt holds the number of cycles since the last transfer, so HOLD and DRAIN share it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) w_nextState = ST_ARB;
            end
            ST_ARB: begin
                if (w_allFin)                           w_nextState = ST_DRAIN;
                else if (w_xfer && ISSUE_INTERVAL > 1)  w_nextState = ST_HOLD;
            end
            ST_HOLD: begin
                if (r_cnt == HOLD_LAST) w_nextState = w_allFin ? ST_DRAIN : ST_ARB;
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_nextState = ST_DONE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        w_reqReady = '0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_ARB: begin
                w_reqReady = w_any ? w_gnt : '0;
                w_busy     = 1'b1;
            end
            ST_HOLD, ST_DRAIN: w_busy = 1'b1;
            ST_DONE:           w_done = 1'b1;
            default: ;
        endcase
    end

    // Counter saturates at ISSUE_INTERVAL so it cannot wrap while waiting for requesters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_outEn      <= 1'b0;
            r_outElement <= '0;
            r_ptr        <= IDX_W'(NUM_REQ - 1);
            r_fin        <= '0;
            r_elemCount  <= '0;
        end else begin
            r_outEn <= w_xfer;
            if (w_xfer) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != DRAIN_LAST) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_xfer) begin
                r_outElement <= bus.req_data[w_gntIdx];
                r_ptr        <= w_gntIdx;
                r_elemCount  <= r_elemCount + COUNT_WIDTH'(1);
                if (bus.req_last[w_gntIdx]) r_fin[w_gntIdx] <= 1'b1;
            end
            if (w_startJob) begin
                r_fin       <= '0;
                r_elemCount <= '0;
            end
        end
    end

    assign bus.req_ready   = w_reqReady;
    assign bus.out_en      = r_outEn;
    assign bus.out_element = r_outElement;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.elem_count  = r_elemCount;

endmodule

// File: tb/tb_reorder_input_arbiter.sv
// Randomized bench for reorder_input_arbiter against a cycle-level model of the arbitration rules.
module tb_reorder_input_arbiter;

    localparam int NR = 4;
    localparam int TW = 128;
    localparam int CW = 32;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    typedef struct packed {
        logic          last;
        logic [TW-1:0] data;
    } item_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [NR-1:0]          reqValid;
    logic [NR-1:0]          reqLast;
    logic [NR-1:0][TW-1:0]  reqData;
    bit                     sel;

    logic [NR-1:0]          obsReady;
    logic                   obsOutEn;
    logic [TW-1:0]          obsElem;
    logic                   obsBusy;
    logic                   obsDone;
    logic [CW-1:0]          obsCount;

    int passCount  = 0;
    int checkCount = 0;

    int             mPhase;
    int             mPtr;
    int             mLastGrant;
    int             mDoneAt;
    int             cyc;
    int             ii;
    int             gapPct;
    logic [NR-1:0]  enMask;
    logic [NR-1:0]  mFin;
    logic [CW-1:0]  mCount;
    logic [TW-1:0]  mLastData;
    bit             mPendOut;
    item_t          srcQ[NR][$];

    reorder_input_arbiter_if #(.NUM_REQ(NR), .TENSOR_WIDTH(TW), .COUNT_WIDTH(CW)) bus3 ();
    reorder_input_arbiter_if #(.NUM_REQ(NR), .TENSOR_WIDTH(TW), .COUNT_WIDTH(CW)) bus1 ();

    assign bus3.start     = start & ~sel;
    assign bus3.req_valid = sel ? '0 : reqValid;
    assign bus3.req_last  = reqLast;
    assign bus3.req_data  = reqData;
    assign bus1.start     = start & sel;
    assign bus1.req_valid = sel ? reqValid : '0;
    assign bus1.req_last  = reqLast;
    assign bus1.req_data  = reqData;

    assign obsReady = sel ? bus1.req_ready   : bus3.req_ready;
    assign obsOutEn = sel ? bus1.out_en      : bus3.out_en;
    assign obsElem  = sel ? bus1.out_element : bus3.out_element;
    assign obsBusy  = sel ? bus1.busy        : bus3.busy;
    assign obsDone  = sel ? bus1.done        : bus3.done;
    assign obsCount = sel ? bus1.elem_count  : bus3.elem_count;

    reorder_input_arbiter #(
        .NUM_REQ(NR), .TENSOR_WIDTH(TW), .ISSUE_INTERVAL(3), .COUNT_WIDTH(CW)
    ) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    reorder_input_arbiter #(
        .NUM_REQ(NR), .TENSOR_WIDTH(TW), .ISSUE_INTERVAL(1), .COUNT_WIDTH(CW)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        checkCount++;
        if (obs !== exp) $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", tag, cyc, obs, exp);
        else passCount++;
    endtask

    task automatic modelReset();
        mPhase     = P_IDLE;
        mPtr       = NR - 1;
        mFin       = '0;
        mCount     = '0;
        mLastData  = '0;
        mPendOut   = 1'b0;
        mLastGrant = -1000;
        mDoneAt    = -1;
    endtask

    // Grant rule: only while a job runs, ISSUE_INTERVAL after the last grant, first eligible after mPtr.
    function automatic int expectedGrant(input logic [NR-1:0] v);
        if (mPhase != P_RUN || cyc < mLastGrant + ii || &mFin) return -1;
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (mPtr + k) % NR;
            if (v[idx] && !mFin[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic fillQueues(input int n, input bit withLast);
        item_t it;
        for (int i = 0; i < NR; i++) begin
            srcQ[i].delete();
            for (int k = 0; k < n; k++) begin
                it.data = {$urandom(), $urandom(), $urandom(), $urandom()};
                it.last = withLast && (k == n - 1);
                srcQ[i].push_back(it);
            end
            if (withLast) begin
                it.data = {$urandom(), $urandom(), $urandom(), $urandom()};
                it.last = 1'b0;
                srcQ[i].push_back(it);
            end
        end
    endtask

    task automatic applyStimulus(input bit startIn, input bit rstIn);
        int            g;
        int            curPhase;
        item_t         it;
        logic [NR-1:0] expMask;
        @(negedge clk);
        checkOutput("outEn",      TW'(obsOutEn), TW'(mPendOut));
        checkOutput("outElement", obsElem, mLastData);
        checkOutput("busy",       TW'(obsBusy), TW'(mPhase == P_RUN));
        checkOutput("done",       TW'(obsDone), TW'(mPhase == P_DONE));
        checkOutput("elemCount",  TW'(obsCount), TW'(mCount));
        rst   = rstIn;
        start = startIn;
        for (int i = 0; i < NR; i++) begin
            if (srcQ[i].size() > 0) begin
                reqData[i]  = srcQ[i][0].data;
                reqLast[i]  = srcQ[i][0].last;
                reqValid[i] = enMask[i] && ($urandom_range(99) >= gapPct);
            end else begin
                reqData[i]  = '0;
                reqLast[i]  = 1'b0;
                reqValid[i] = 1'b0;
            end
        end
        #1;
        g       = expectedGrant(reqValid);
        expMask = (g >= 0) ? (NR'(1) << g) : '0;
        checkOutput("reqReady", TW'(obsReady), TW'(expMask));
        curPhase = mPhase;
        if (!rstIn) begin
            modelReset();
        end else begin
            mPendOut = 1'b0;
            if (g >= 0) begin
                it         = srcQ[g].pop_front();
                mPendOut   = 1'b1;
                mLastData  = it.data;
                mCount     = mCount + 1;
                mPtr       = g;
                mLastGrant = cyc;
                if (it.last) mFin[g] = 1'b1;
                if (&mFin) mDoneAt = cyc + 1 + ii;
            end
            if (mPhase == P_RUN && mDoneAt >= 0 && cyc + 1 >= mDoneAt) mPhase = P_DONE;
            if (startIn && curPhase != P_RUN) begin
                mPhase  = P_RUN;
                mFin    = '0;
                mCount  = '0;
                mDoneAt = -1;
            end
        end
        cyc++;
    endtask

    task automatic runUntilDone(input int budget);
        int n = 0;
        while (mPhase != P_DONE && n < budget) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        if (mPhase != P_DONE) checkOutput("doneTimeout", TW'(obsDone), TW'(1'b1));
    endtask

    initial begin
        sel      = 1'b0;
        ii       = 3;
        rst      = 1'b0;
        start    = 1'b0;
        reqValid = '0;
        reqLast  = '0;
        reqData  = '0;
        cyc      = 0;
        gapPct   = 0;
        enMask   = '1;
        modelReset();
        fillQueues(8, 1'b0);

        // reset held with every requester valid, then idle without start
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b1);

        // fairness with all four requesters streaming
        fillQueues(20, 1'b0);
        applyStimulus(1'b1, 1'b1);
        repeat (36) applyStimulus(1'b0, 1'b1);

        // sparse: only requesters 1 and 3
        applyStimulus(1'b0, 1'b0);
        enMask = 4'b1010;
        fillQueues(20, 1'b0);
        applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b1);

        // end-of-stream, five elements each, random valid gaps, finished requesters stay valid
        applyStimulus(1'b0, 1'b0);
        enMask = '1;
        gapPct = 30;
        fillQueues(5, 1'b1);
        applyStimulus(1'b1, 1'b1);
        runUntilDone(400);
        checkOutput("eosCount", TW'(obsCount), TW'(20));
        repeat (5) applyStimulus(1'b0, 1'b1);
        fillQueues(2, 1'b1);
        applyStimulus(1'b1, 1'b1);
        runUntilDone(200);
        checkOutput("restartCount", TW'(obsCount), TW'(8));

        // reset during HOLD, restart, then an ignored start while arbitrating
        gapPct = 0;
        applyStimulus(1'b0, 1'b0);
        fillQueues(20, 1'b0);
        applyStimulus(1'b1, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b1);
        for (int n = 0; n < 10 && !mPendOut; n++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("firstGrantAfterReset", TW'(obsReady), TW'(4'b0001));
        repeat (2) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b1);

        // back-to-back issue on the ISSUE_INTERVAL=1 instance
        applyStimulus(1'b0, 1'b0);
        sel = 1'b1;
        ii  = 1;
        applyStimulus(1'b0, 1'b1);
        fillQueues(20, 1'b0);
        applyStimulus(1'b1, 1'b1);
        repeat (20) applyStimulus(1'b0, 1'b1);
        gapPct = 25;
        repeat (30) applyStimulus(1'b0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
